parser_head_builder: RTL

- Ingress stage directly upstream of the first parser layer.
- Accepts a narrow packet beat stream plus a per-packet metadata word.
- Assembles the first HEAD_WIDTH bits of each packet into a tagged head vector and a tagged meta vector, which feed the layer's head and meta inputs.
- Forwards the remaining payload beats on a separate stream, in order, after the head has been accepted.

---
 rtl/parser_head_builder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/parser_head_builder.sv
// Ingress head builder: packs the first HEAD_WIDTH bits of each packet into a
// tagged head/meta pair for the first parser layer and streams the remainder.
module parser_head_builder #(
  parameter int unsigned DATA_WIDTH       = 128,
  parameter int unsigned HEAD_WIDTH       = 512,
  parameter int unsigned META_WIDTH       = 512,
  parameter int unsigned META_SHIFT_WIDTH = 5,
  parameter int unsigned TAG_WIDTH        = 9
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_data_valid,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_data_sop,
  input  logic                             i_data_eop,
  output logic                             o_data_ready,
  input  logic                             i_meta_valid,
  input  logic [META_WIDTH-1:0]            i_meta,
  output logic                             o_head_valid,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta,
  input  logic                             i_head_ready,
  output logic                             o_pay_valid,
  output logic [DATA_WIDTH-1:0]            o_pay_data,
  output logic                             o_pay_eop,
  input  logic                             i_pay_ready,
  output logic [31:0]                      o_pkt_cnt,
  output logic [15:0]                      o_err_cnt
);

  localparam int unsigned HEAD_BEATS = HEAD_WIDTH / DATA_WIDTH;
  localparam int unsigned CNT_W      = $clog2(HEAD_BEATS + 1);
  localparam int unsigned START_BIT  = META_SHIFT_WIDTH;
  localparam int unsigned TAIL_BIT   = META_SHIFT_WIDTH + 1;
  localparam int unsigned VALID_BIT  = META_SHIFT_WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [HEAD_WIDTH-1:0]   r_head;
  logic [META_WIDTH-1:0]   r_meta;
  logic [TAG_WIDTH-1:0]    r_head_tag;
  logic [TAG_WIDTH-1:0]    r_meta_tag;
  logic [31:0]             r_pkt_cnt;
  logic [15:0]             r_err_cnt;

  logic                    w_load_sop;
  logic                    w_wr_beat;
  logic                    w_abort;
  logic                    w_head_acc;
  logic                    w_pay_acc;
  logic                    w_sop_to_emit;
  logic                    w_last_beat;

  // Tag: shift offset zero, START set, SHIFT clear.
  function automatic logic [TAG_WIDTH-1:0] make_tag(input logic tail, input logic vld);
    logic [TAG_WIDTH-1:0] t;
    t            = '0;
    t[START_BIT] = 1'b1;
    t[TAIL_BIT]  = tail;
    t[VALID_BIT] = vld;
    return t;
  endfunction

  assign w_sop_to_emit = i_data_eop | (HEAD_BEATS == 1);
  assign w_last_beat   = i_data_eop | (r_cnt == CNT_W'(HEAD_BEATS - 1));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load_sop) w_next = w_sop_to_emit ? S_EMIT : S_COLLECT;
      end
      S_COLLECT: begin
        if (w_load_sop)                    w_next = w_sop_to_emit ? S_EMIT : S_COLLECT;
        else if (w_wr_beat && w_last_beat) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (w_head_acc) w_next = r_head_tag[TAIL_BIT] ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (w_pay_acc && (i_data_eop || i_data_sop)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output and datapath-enable logic
  always_comb begin
    o_data_ready = 1'b0;
    o_head_valid = 1'b0;
    o_pay_valid  = 1'b0;
    o_pay_data   = '0;
    o_pay_eop    = 1'b0;
    w_load_sop   = 1'b0;
    w_wr_beat    = 1'b0;
    w_abort      = 1'b0;
    w_head_acc   = 1'b0;
    w_pay_acc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_data_ready = 1'b1;
        w_load_sop   = i_data_valid & i_data_sop;
      end
      S_COLLECT: begin
        o_data_ready = 1'b1;
        w_load_sop   = i_data_valid & i_data_sop;
        w_abort      = i_data_valid & i_data_sop;
        w_wr_beat    = i_data_valid & ~i_data_sop;
      end
      S_EMIT: begin
        o_head_valid = 1'b1;
        w_head_acc   = i_head_ready;
      end
      S_PAYLOAD: begin
        o_data_ready = i_pay_ready;
        o_pay_valid  = i_data_valid;
        o_pay_data   = i_data;
        // A stray sop closes the current packet on the payload stream.
        o_pay_eop    = i_data_eop | i_data_sop;
        w_pay_acc    = i_data_valid & i_pay_ready;
        w_abort      = i_data_valid & i_pay_ready & i_data_sop;
      end
      default: ;
    endcase
  end

  // Head/meta assembly and counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_head     <= '0;
      r_meta     <= '0;
      r_head_tag <= '0;
      r_meta_tag <= '0;
      r_pkt_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_load_sop) begin
        r_cnt      <= CNT_W'(1);
        r_head     <= HEAD_WIDTH'(i_data) << (HEAD_WIDTH - DATA_WIDTH);
        r_meta     <= i_meta_valid ? i_meta : '0;
        r_head_tag <= make_tag(i_data_eop, 1'b1);
        r_meta_tag <= make_tag(i_data_eop, i_meta_valid);
      end else if (w_wr_beat) begin
        r_cnt <= r_cnt + CNT_W'(1);
        for (int b = 1; b < HEAD_BEATS; b++) begin
          if (r_cnt == CNT_W'(b)) r_head[HEAD_WIDTH-1-b*DATA_WIDTH -: DATA_WIDTH] <= i_data;
        end
        if (i_data_eop) begin
          r_head_tag[TAIL_BIT] <= 1'b1;
          r_meta_tag[TAIL_BIT] <= 1'b1;
        end
      end
      if (w_head_acc) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_abort && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_head    = {r_head_tag, r_head};
  assign o_meta    = {r_meta_tag, r_meta};
  assign o_pkt_cnt = r_pkt_cnt;
  assign o_err_cnt = r_err_cnt;

endmodule
